power_cap_controller: RTL and testbench

POWER_CAP_CONTROLLER -- requirements
Module: power_cap_controller

---
 rtl/power_pkg.sv | 30 +++
 rtl/power_cap_checker.sv | 37 +++
 rtl/power_window_avg.sv | 47 ++++
 rtl/power_cap_controller.sv | 170 +++++++++++++++++
 tb/tb_power_cap_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/power_pkg.sv
// Shared types for the power-capping block: level encoding, FSM states and
// power-domain widths used by the controller, its window averager and checker.
package power_pkg;

    typedef logic [2:0]  level_t;
    typedef logic [15:0] power_mw_t;
    typedef logic [23:0] power_acc_t;
    typedef logic [16:0] power_wide_t;

    localparam level_t LEVEL_MIN = 3'd0;
    localparam level_t LEVEL_MAX = 3'd7;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        VREQ_UP = 2'd1,
        VREQ_DN = 2'd2,
        SETTLE  = 2'd3
    } cap_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/power_cap_checker.sv
// Protocol and invariant properties for power_cap_controller outputs; meant to
// be instantiated alongside the controller in simulation.
module power_cap_checker
    import power_pkg::*;
(
    input logic        clk,
    input logic        rst,
    input level_t      voltage_level,
    input level_t      frequency_level,
    input logic        vreg_req,
    input level_t      vreg_target,
    input logic        vreg_error,
    input logic [15:0] violation_count
);

    property p_freq_le_volt;
        @(posedge clk) disable iff (rst) frequency_level <= voltage_level;
    endproperty

    property p_target_stable;
        @(posedge clk) (vreg_req && !rst) |=> (!vreg_req || (vreg_target == $past(vreg_target)));
    endproperty

    property p_error_sticky;
        @(posedge clk) (vreg_error && !rst) |=> vreg_error;
    endproperty

    property p_viol_monotonic;
        @(posedge clk) (!rst) |=> (violation_count >= $past(violation_count));
    endproperty

    a_freq_le_volt:   assert property (p_freq_le_volt);
    a_target_stable:  assert property (p_target_stable);
    a_error_sticky:   assert property (p_error_sticky);
    a_viol_monotonic: assert property (p_viol_monotonic);

endmodule

// File: rtl/power_window_avg.sv
// Sliding-free block averager: sums 2^SAMPLE_LOG2 samples and strobes the mean
// on the last sample of each window. Dropping enable discards the window.
module power_window_avg
    import power_pkg::*;
#(
    parameter int SAMPLE_LOG2 = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    input  power_mw_t total_power,
    output logic      avg_strobe,
    output power_mw_t avg
);

    localparam logic [SAMPLE_LOG2-1:0] CNT_LAST = {SAMPLE_LOG2{1'b1}};
    localparam logic [SAMPLE_LOG2-1:0] CNT_ONE  = SAMPLE_LOG2'(1'b1);

    logic [SAMPLE_LOG2-1:0] win_cnt_r;
    power_acc_t             acc_r;
    power_acc_t             sum_s;

    // Sum including the current sample, so the mean covers the whole window
    always_comb begin
        sum_s      = acc_r + power_acc_t'(total_power);
        avg_strobe = enable && (win_cnt_r == CNT_LAST);
        avg        = power_mw_t'(sum_s >> SAMPLE_LOG2);
    end

    // Window counter and accumulator; cleared whenever sampling is paused
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_r <= '0;
            acc_r     <= 24'd0;
        end else if (!enable) begin
            win_cnt_r <= '0;
            acc_r     <= 24'd0;
        end else if (win_cnt_r == CNT_LAST) begin
            win_cnt_r <= '0;
            acc_r     <= 24'd0;
        end else begin
            win_cnt_r <= win_cnt_r + CNT_ONE;
            acc_r     <= sum_s;
        end
    end

endmodule

// File: rtl/power_cap_controller.sv
// Closed-loop V/F capping: averages chip power per window, steps the level
// down/up against a budget with hysteresis, and handshakes voltage changes.
module power_cap_controller
    import power_pkg::*;
#(
    parameter int SAMPLE_LOG2   = 8,
    parameter int HYST_MW       = 200,
    parameter int SETTLE_CYCLES = 64,
    parameter int ACK_TIMEOUT   = 1024,
    parameter int RESET_LEVEL   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] total_power,
    input  logic [15:0] budget_mw,
    input  logic        cap_enable,
    input  logic [2:0]  max_level,
    output logic [2:0]  voltage_level,
    output logic [2:0]  frequency_level,
    output logic        vreg_req,
    output logic [2:0]  vreg_target,
    input  logic        vreg_ack,
    output logic        throttled,
    output logic        vreg_error,
    output logic [15:0] violation_count
);

    localparam level_t      RESET_LVL   = level_t'(RESET_LEVEL);
    localparam power_wide_t HYST_W      = power_wide_t'(HYST_MW);
    localparam logic [15:0] ACK_LAST    = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    cap_state_t  state_r;
    level_t      volt_r;
    level_t      freq_r;
    level_t      target_r;
    logic        req_r;
    logic        err_r;
    logic        throttled_r;
    logic [15:0] viol_r;
    logic [15:0] timer_r;

    logic        avg_strobe_s;
    power_mw_t   avg_s;
    logic        over_s;
    logic        under_s;
    logic        force_dn_s;
    logic        step_dn_s;
    logic        step_up_s;
    level_t      freq_nxt_s;

    power_window_avg #(
        .SAMPLE_LOG2 (SAMPLE_LOG2)
    ) u_window (
        .clk         (clk),
        .rst         (rst),
        .enable      (state_r == MONITOR),
        .total_power (total_power),
        .avg_strobe  (avg_strobe_s),
        .avg         (avg_s)
    );

    // Window decision terms; a lowered max_level forces a step without a window
    always_comb begin
        over_s     = avg_s > budget_mw;
        under_s    = ({1'b0, avg_s} + HYST_W) < {1'b0, budget_mw};
        force_dn_s = freq_r > max_level;
        step_dn_s  = force_dn_s ||
                     (avg_strobe_s && cap_enable && over_s && (freq_r != LEVEL_MIN));
        step_up_s  = !force_dn_s && avg_strobe_s && cap_enable && under_s &&
                     (freq_r < max_level) && (freq_r != LEVEL_MAX);
    end

    // Frequency drops ahead of the voltage request and rises only after ack
    always_comb begin
        freq_nxt_s = freq_r;
        case (state_r)
            MONITOR: begin
                if (step_dn_s) begin
                    freq_nxt_s = freq_r - 3'd1;
                end else begin
                    freq_nxt_s = freq_r;
                end
            end
            VREQ_UP: begin
                if (vreg_ack) begin
                    freq_nxt_s = target_r;
                end else begin
                    freq_nxt_s = freq_r;
                end
            end
            default: freq_nxt_s = freq_r;
        endcase
    end

    // Capping FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= MONITOR;
            volt_r      <= RESET_LVL;
            freq_r      <= RESET_LVL;
            target_r    <= LEVEL_MIN;
            req_r       <= 1'b0;
            err_r       <= 1'b0;
            viol_r      <= 16'd0;
            timer_r     <= 16'd0;
            throttled_r <= RESET_LVL < max_level;
        end else begin
            freq_r      <= freq_nxt_s;
            throttled_r <= freq_nxt_s < max_level;
            if (avg_strobe_s && over_s) begin
                viol_r <= sat_inc16(viol_r);
            end
            case (state_r)
                MONITOR: begin
                    timer_r <= 16'd0;
                    if (step_dn_s) begin
                        state_r  <= VREQ_DN;
                        req_r    <= 1'b1;
                        target_r <= freq_r - 3'd1;
                    end else if (step_up_s) begin
                        state_r  <= VREQ_UP;
                        req_r    <= 1'b1;
                        target_r <= freq_r + 3'd1;
                    end
                end
                VREQ_UP, VREQ_DN: begin
                    if (vreg_ack) begin
                        volt_r   <= target_r;
                        req_r    <= 1'b0;
                        target_r <= LEVEL_MIN;
                        state_r  <= SETTLE;
                        timer_r  <= 16'd0;
                    end else if (timer_r == ACK_LAST) begin
                        err_r    <= 1'b1;
                        req_r    <= 1'b0;
                        target_r <= LEVEL_MIN;
                        state_r  <= SETTLE;
                        timer_r  <= 16'd0;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        state_r <= MONITOR;
                        timer_r <= 16'd0;
                    end else begin
                        timer_r <= timer_r + 16'd1;
                    end
                end
                default: begin
                    state_r  <= MONITOR;
                    req_r    <= 1'b0;
                    target_r <= LEVEL_MIN;
                    timer_r  <= 16'd0;
                end
            endcase
        end
    end

    assign voltage_level   = volt_r;
    assign frequency_level = freq_r;
    assign vreg_req        = req_r;
    assign vreg_target     = target_r;
    assign vreg_error      = err_r;
    assign throttled       = throttled_r;
    assign violation_count = viol_r;

endmodule

// File: tb/tb_power_cap_controller.sv
// Scoreboard bench for power_cap_controller: a window/deadline reference model
// predicts every cycle's outputs and each regulator request.
module tb_power_cap_controller;

    localparam int SL     = 4;
    localparam int WIN    = 16;
    localparam int SETTLE = 8;
    localparam int ACKTO  = 16;
    localparam int RLVL   = 3;
    localparam int HYST   = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] total_power;
    logic [15:0] budget_mw;
    logic        cap_enable;
    logic [2:0]  max_level;
    logic        vreg_ack;
    logic [2:0]  voltage_level;
    logic [2:0]  frequency_level;
    logic        vreg_req;
    logic [2:0]  vreg_target;
    logic        throttled;
    logic        vreg_error;
    logic [15:0] violation_count;

    always #5 clk = ~clk;

    power_cap_controller #(
        .SAMPLE_LOG2   (SL),
        .HYST_MW       (HYST),
        .SETTLE_CYCLES (SETTLE),
        .ACK_TIMEOUT   (ACKTO),
        .RESET_LEVEL   (RLVL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .total_power     (total_power),
        .budget_mw       (budget_mw),
        .cap_enable      (cap_enable),
        .max_level       (max_level),
        .voltage_level   (voltage_level),
        .frequency_level (frequency_level),
        .vreg_req        (vreg_req),
        .vreg_target     (vreg_target),
        .vreg_ack        (vreg_ack),
        .throttled       (throttled),
        .vreg_error      (vreg_error),
        .violation_count (violation_count)
    );

    power_cap_checker u_chk (
        .clk             (clk),
        .rst             (rst),
        .voltage_level   (voltage_level),
        .frequency_level (frequency_level),
        .vreg_req        (vreg_req),
        .vreg_target     (vreg_target),
        .vreg_error      (vreg_error),
        .violation_count (violation_count)
    );

    typedef struct {
        int volt; int freq; bit req; int target; bit err; int viol; bit thr;
    } snap_t;
    typedef struct { int target; int freq; int volt; } req_t;

    snap_t exp_q[$];
    req_t  req_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state (deadline/countdown view, window as a sample list)
    int m_volt, m_freq, m_target, m_viol, m_wait, m_settle;
    bit m_req, m_up, m_err;
    int win[$];

    int ack_delay = 5;
    bit rand_ack  = 1'b0;
    bit stray     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_req(input bit up);
        if (up) begin
            m_target = m_freq + 1;
        end else begin
            m_freq   = m_freq - 1;
            m_target = m_freq;
        end
        m_up  = up;
        m_req = 1'b1;
        m_wait = 0;
        win.delete();
    endtask

    task automatic model_step(input bit r, input int tp, input int bud, input bit cen,
                              input int maxl, input bit ack);
        int  sum;
        int  avg;
        bit  full;
        bit  was_req;
        snap_t s;
        was_req = m_req;
        avg = 0;
        if (r) begin
            m_volt = RLVL; m_freq = RLVL; m_req = 1'b0; m_target = 0; m_err = 1'b0;
            m_viol = 0; m_wait = 0; m_settle = 0; m_up = 1'b0;
            win.delete();
        end else if (m_req) begin
            if (ack) begin
                m_volt = m_target;
                if (m_up) m_freq = m_target;
                m_req = 1'b0;
                m_settle = SETTLE;
            end else begin
                m_wait++;
                if (m_wait == ACKTO) begin
                    m_err = 1'b1;
                    m_req = 1'b0;
                    m_settle = SETTLE;
                end
            end
        end else if (m_settle > 0) begin
            m_settle--;
            win.delete();
        end else begin
            win.push_back(tp);
            full = (win.size() == WIN);
            if (full) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                avg = sum / WIN;
                if (avg > bud && m_viol < 65535) m_viol++;
                win.delete();
            end
            if (m_freq > maxl) start_req(1'b0);
            else if (full && cen && avg > bud && m_freq > 0) start_req(1'b0);
            else if (full && cen && (avg + HYST) < bud && m_freq < maxl) start_req(1'b1);
        end
        if (!was_req && m_req) req_q.push_back('{m_target, m_freq, m_volt});
        s.volt = m_volt; s.freq = m_freq; s.req = m_req; s.target = m_target;
        s.err = m_err; s.viol = m_viol; s.thr = (m_freq < maxl);
        exp_q.push_back(s);
    endtask

    task automatic cycle(input bit r, input int tp, input int bud, input bit cen, input int maxl);
        bit a;
        bit was;
        @(negedge clk);
        if (m_req) a = (ack_delay >= 0) && (m_wait == ack_delay);
        else       a = stray && ($urandom_range(0, 9) == 0);
        rst         = r;
        total_power = 16'(tp);
        budget_mw   = 16'(bud);
        cap_enable  = cen;
        max_level   = 3'(maxl);
        vreg_ack    = a;
        was = m_req;
        model_step(r, tp, bud, cen, maxl, a);
        if (!was && m_req && rand_ack) ack_delay = $urandom_range(0, 20);
    endtask

    // Monitor: compare every predicted cycle and every new regulator request
    bit prev_req = 1'b0;
    initial begin
        snap_t e;
        req_t  q;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("voltage_level", voltage_level, e.volt);
                chk("frequency_level", frequency_level, e.freq);
                chk("vreg_req", vreg_req, e.req);
                if (e.req) chk("vreg_target", vreg_target, e.target);
                chk("vreg_error", vreg_error, e.err);
                chk("violation_count", violation_count, e.viol);
                chk("throttled", throttled, e.thr);
                chk("freq_le_volt", frequency_level <= voltage_level, 1);
                if (vreg_req === 1'b1 && !prev_req) begin
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: got target %0d expected no request at %0t",
                                 vreg_target, $time);
                    end else begin
                        q = req_q.pop_front();
                        chk("req_target", vreg_target, q.target);
                        chk("req_freq", frequency_level, q.freq);
                        chk("req_volt", voltage_level, q.volt);
                    end
                end
                prev_req = (vreg_req === 1'b1);
            end
        end
    end

    initial begin
        int base, bud, maxl, tp;
        bit cen, reached;
        rst = 1'b1; total_power = 16'd0; budget_mw = 16'd2500;
        cap_enable = 1'b1; max_level = 3'd7; vreg_ack = 1'b0;

        // step-down, ack five cycles into the request
        repeat (3) cycle(1'b1, 3000, 2500, 1'b1, 7);
        ack_delay = 5;
        repeat (60) cycle(1'b0, 3000, 2500, 1'b1, 7);

        // step-up below budget minus hysteresis
        repeat (2) cycle(1'b1, 2000, 2500, 1'b1, 7);
        ack_delay = 3;
        repeat (60) cycle(1'b0, 2000, 2500, 1'b1, 7);

        // inside the hysteresis band, with stray acks that must be ignored
        repeat (2) cycle(1'b1, 2350, 2500, 1'b1, 7);
        stray = 1'b1;
        repeat (160) cycle(1'b0, 2350, 2500, 1'b1, 7);
        stray = 1'b0;

        // regulator never answers
        repeat (2) cycle(1'b1, 3000, 2500, 1'b1, 7);
        ack_delay = -1;
        repeat (60) cycle(1'b0, 3000, 2500, 1'b1, 7);

        // max_level lowered below current level
        repeat (2) cycle(1'b1, 2400, 2500, 1'b1, 7);
        ack_delay = 2;
        repeat (10) cycle(1'b0, 2400, 2500, 1'b1, 7);
        repeat (60) cycle(1'b0, 2400, 2500, 1'b1, 1);

        // reset in the middle of a step-down handshake
        repeat (2) cycle(1'b1, 3000, 2500, 1'b1, 7);
        ack_delay = -1;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            cycle(1'b0, 3000, 2500, 1'b1, 7);
            if (m_req && !m_up) reached = 1'b1;
        end
        chk("reach_vreq_dn", reached, 1);
        cycle(1'b1, 3000, 2500, 1'b1, 7);
        repeat (5) cycle(1'b0, 3000, 2500, 1'b1, 7);

        // randomized traffic
        rand_ack = 1'b1; stray = 1'b1;
        base = 2500; bud = 2500; maxl = 7;
        cycle(1'b1, base, bud, 1'b1, maxl);
        for (int i = 0; i < 4000; i++) begin
            if (i % 48 == 0) base = $urandom_range(1800, 3200);
            if ($urandom_range(0, 299) == 0) bud = $urandom_range(2000, 3000);
            if ($urandom_range(0, 249) == 0) maxl = $urandom_range(0, 7);
            cen = ($urandom_range(0, 19) != 0);
            tp  = base + $urandom_range(0, 400) - 200;
            cycle(($urandom_range(0, 1499) == 0), tp, bud, cen, maxl);
        end

        @(posedge clk);
        #2;
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
